// File: rtl/mau_pkg.sv
// Shared encodings and the request legality check for the memory access unit.
package mau_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RD   = 2'b01,
    S_WR   = 2'b10,
    S_RESP = 2'b11
  } state_e;

  // Size is checked first, then alignment, then range.
  function automatic logic access_error(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input int unsigned mem_bytes);
    if (size == 2'b11) return 1'b1;
    if (size == SZ_H && addr[0]) return 1'b1;
    if (size == SZ_W && addr[1:0] != 2'b00) return 1'b1;
    return addr >= mem_bytes;
  endfunction

endpackage

// File: rtl/mau_lane.sv
// Byte-lane steering: extracts and extends load data, and merges store data
// into a captured memory word.
module mau_lane
  import mau_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = word[{addr, 3'b000} +: 8];
  assign lane_h = word[{addr[1], 4'b0000} +: 16];

  always_comb begin
    load_data  = '0;
    store_word = word;
    case (size)
      SZ_B: begin
        load_data = {{24{lane_b[7] & ~uns}}, lane_b};
        store_word[{addr, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_H: begin
        load_data = {{16{lane_h[15] & ~uns}}, lane_h};
        store_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      end
      SZ_W: begin
        load_data  = word;
        store_word = wdata;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the MEM stage: one request at a time, sub-word
// stores done as read-modify-write against a 32-bit-wide memory.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  state_e      state, state_next;
  logic        we_q, uns_q;
  logic [1:0]  size_q, lane_q;
  logic [31:0] wdata_q, word_q, mem_addr_q;
  logic        accept, req_err;
  logic [31:0] lane_word, load_data, store_word;

  assign accept    = req_valid && (state == S_IDLE);
  assign req_err   = access_error(req_size, req_addr, MEM_BYTES);
  assign mem_addr  = mem_addr_q;
  // During RD the lane logic works on the live memory word so the load
  // result can be registered in the same edge that captures it.
  assign lane_word = (state == S_RD) ? mem_rd : word_q;

  mau_lane u_lane (
    .word       (lane_word),
    .addr       (lane_q),
    .size       (size_q),
    .uns        (uns_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                          state_next = S_RESP;
          else if (req_we && req_size == SZ_W)  state_next = S_WR;
          else                                  state_next = S_RD;
        end
      end
      S_RD:    state_next = we_q ? S_WR : S_RESP;
      S_WR:    state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_wd     = '0;
    case (state)
      S_IDLE: req_ready  = 1'b1;
      S_RD:   mem_read   = 1'b1;
      S_WR: begin
        mem_write = 1'b1;
        mem_wd    = store_word;
      end
      S_RESP: resp_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= SZ_B;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      word_q     <= '0;
      mem_addr_q <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            we_q       <= req_we;
            uns_q      <= req_unsigned;
            size_q     <= req_size;
            lane_q     <= req_addr[1:0];
            wdata_q    <= req_wdata;
            mem_addr_q <= {req_addr[31:2], 2'b00};
            resp_rdata <= '0;
            resp_err   <= req_err;
          end
        end
        S_RD: begin
          word_q <= mem_rd;
          if (!we_q) resp_rdata <= load_data;
        end
        default: ;
      endcase
    end
  end

endmodule
